vga_timing_generator: RTL and testbench

Generates the VGA raster for the display path: divides the system clock into a pixel-rate enable, runs horizontal/vertical position counters over the full 800×525 frame, and decodes sync and blanking. Its `hs`/`vs` counter outputs feed the image drawer directly, which maps them to a frame-buffer address and RGB. The sync/blank outputs and `vga_clk` drive the board video DAC.

---
 rtl/vga_timing_generator.sv | 102 ++++++++++
 tb/tb_vga_timing_generator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical position counters,
// and registered sync/blank/frame-start decode aligned with the presented counters.
module vga_timing_generator #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hs,
  output logic [9:0] vs,
  output logic       pixel_tick,
  output logic       vga_clk,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_generator: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || (CLK_DIV > 1 && (CLK_DIV % 2) != 0)) begin : g_bad_div
    $error("vga_timing_generator: CLK_DIV must be 1 or an even number >= 2");
  end

  logic [DW-1:0] div;
  logic [DW-1:0] div_nx;
  logic [9:0]    hs_nx;
  logic [9:0]    vs_nx;
  logic          tick;

  always_comb begin
    tick   = (div == DIV_LAST);
    div_nx = tick ? '0 : div + 1'b1;
    hs_nx  = hs;
    vs_nx  = vs;
    if (tick) begin
      if (hs == H_LAST) begin
        hs_nx = '0;
        vs_nx = (vs == V_LAST) ? '0 : vs + 10'd1;
      end else begin
        hs_nx = hs + 10'd1;
      end
    end
  end

  assign pixel_tick = tick;

  // Decode from next-state counters so the registered flags line up with hs/vs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      hs          <= '0;
      vs          <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nx;
      hs          <= hs_nx;
      vs          <= vs_nx;
      hsync_n     <= !(hs_nx >= HS_START && hs_nx < HS_END);
      vsync_n     <= !(vs_nx >= VS_START && vs_nx < VS_END);
      blank_n     <= (hs_nx < H_ACT) && (vs_nx < V_ACT);
      frame_start <= tick && (hs == H_LAST) && (vs == V_LAST);
    end
  end

  if (CLK_DIV > 1) begin : g_vclk
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vga_clk <= 1'b0;
      else     vga_clk <= (div_nx >= DIV_HALF);
    end
  end else begin : g_no_vclk
    // At one clock per pixel the DAC is clocked from clk directly.
    assign vga_clk = 1'b0;
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: four parameterisations checked every cycle
// against an arithmetic raster model, plus constant checkpoint tables and counts.
module tb_vga_timing_generator;

  typedef struct packed {
    logic [9:0] hs;
    logic [9:0] vs;
    logic       tick;
    logic       vclk;
    logic       hsn;
    logic       vsn;
    logic       bn;
    logic       fs;
  } obs_t;

  typedef struct {
    int unsigned n;
    logic [9:0]  hs;
    logic [9:0]  vs;
    logic        tick;
    logic        hsn;
    logic        bn;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [9:0] hs_w [4];
  logic [9:0] vs_w [4];
  logic       tick_w [4];
  logic       vclk_w [4];
  logic       hsn_w [4];
  logic       vsn_w [4];
  logic       bn_w [4];
  logic       fs_w [4];

  int          vectors;
  int          miscompares;
  int unsigned n;

  // d0: default timing; d1: reduced raster (32x20); d2: CLK_DIV=4; d3: CLK_DIV=1
  vga_timing_generator #(.CLK_DIV(2)) d0 (
    .clk(clk), .rst(rst), .hs(hs_w[0]), .vs(vs_w[0]), .pixel_tick(tick_w[0]),
    .vga_clk(vclk_w[0]), .hsync_n(hsn_w[0]), .vsync_n(vsn_w[0]),
    .blank_n(bn_w[0]), .frame_start(fs_w[0]));

  vga_timing_generator #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
                         .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(6)) d1 (
    .clk(clk), .rst(rst), .hs(hs_w[1]), .vs(vs_w[1]), .pixel_tick(tick_w[1]),
    .vga_clk(vclk_w[1]), .hsync_n(hsn_w[1]), .vsync_n(vsn_w[1]),
    .blank_n(bn_w[1]), .frame_start(fs_w[1]));

  vga_timing_generator #(.CLK_DIV(4)) d2 (
    .clk(clk), .rst(rst), .hs(hs_w[2]), .vs(vs_w[2]), .pixel_tick(tick_w[2]),
    .vga_clk(vclk_w[2]), .hsync_n(hsn_w[2]), .vsync_n(vsn_w[2]),
    .blank_n(bn_w[2]), .frame_start(fs_w[2]));

  vga_timing_generator #(.CLK_DIV(1)) d3 (
    .clk(clk), .rst(rst), .hs(hs_w[3]), .vs(vs_w[3]), .pixel_tick(tick_w[3]),
    .vga_clk(vclk_w[3]), .hsync_n(hsn_w[3]), .vsync_n(vsn_w[3]),
    .blank_n(bn_w[3]), .frame_start(fs_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster position derived purely from elapsed clock edges since reset release.
  function automatic obs_t model(int d, int unsigned cyc);
    int unsigned cd, ha, hf, hy, hb, va, vf, vy, vb, ht, vt, dv, p, h, v;
    obs_t e;
    cd = 2; ha = 640; hf = 16; hy = 96; hb = 48; va = 480; vf = 10; vy = 2; vb = 33;
    if (d == 1) begin
      ha = 16; hf = 4; hy = 8; hb = 4; va = 10; vf = 2; vy = 2; vb = 6;
    end
    if (d == 2) cd = 4;
    if (d == 3) cd = 1;
    ht = ha + hf + hy + hb;
    vt = va + vf + vy + vb;
    dv = cyc % cd;
    p  = cyc / cd;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.hs   = 10'(h);
    e.vs   = 10'(v);
    e.tick = (dv == cd - 1);
    e.vclk = (cd > 1) && (dv >= cd / 2);
    e.hsn  = !(h >= ha + hf && h < ha + hf + hy);
    e.vsn  = !(v >= va + vf && v < va + vf + vy);
    e.bn   = (h < ha) && (v < va);
    e.fs   = (cyc > 0) && (dv == 0) && (p % (ht * vt) == 0);
    return e;
  endfunction

  function automatic obs_t got(int d);
    obs_t g;
    g.hs = hs_w[d]; g.vs = vs_w[d]; g.tick = tick_w[d]; g.vclk = vclk_w[d];
    g.hsn = hsn_w[d]; g.vsn = vsn_w[d]; g.bn = bn_w[d]; g.fs = fs_w[d];
    return g;
  endfunction

  task automatic cmp(string name, int d);
    obs_t g, e;
    g = got(d);
    e = model(d, n);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s dut%0d n=%0d: got hs=%0d vs=%0d tick=%b vclk=%b hsn=%b vsn=%b bn=%b fs=%b, expected hs=%0d vs=%0d tick=%b vclk=%b hsn=%b vsn=%b bn=%b fs=%b",
               name, d, n, g.hs, g.vs, g.tick, g.vclk, g.hsn, g.vsn, g.bn, g.fs,
               e.hs, e.vs, e.tick, e.vclk, e.hsn, e.vsn, e.bn, e.fs);
    end
  endtask

  task automatic check_all(string name);
    for (int d = 0; d < 4; d++) cmp(name, d);
  endtask

  task automatic cmp_int(string name, int g, int e);
    vectors++;
    if (g != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, g, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) n++;
    @(negedge clk);
  endtask

  vec_t tbl [12];
  int   hsn0_low, vsn1_low, vclk2_hi, tick2_cnt, tick3_cnt, fs1_cnt;
  int   fs1_at [2];

  task automatic accumulate();
    if (n < 1600 && hsn_w[0] == 1'b0) hsn0_low++;
    if (n < 1280 && vsn_w[1] == 1'b0) vsn1_low++;
    if (n < 3200 && vclk_w[2] == 1'b1) vclk2_hi++;
    if (n < 3200 && tick_w[2] == 1'b1) tick2_cnt++;
    if (n < 800 && tick_w[3] == 1'b1) tick3_cnt++;
    if (fs_w[1] == 1'b1) begin
      if (fs1_cnt < 2) fs1_at[fs1_cnt] = int'(n);
      fs1_cnt++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; n = 0;
    hsn0_low = 0; vsn1_low = 0; vclk2_hi = 0; tick2_cnt = 0; tick3_cnt = 0; fs1_cnt = 0;
    fs1_at[0] = -1; fs1_at[1] = -1;

    // Default-timing checkpoints, n = clock edges since reset release
    tbl[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{2,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1279, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1280, 10'd640, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1311, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1503, 10'd751, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1504, 10'd752, 10'd0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1599, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1600, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{3201, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    #1;
    check_all("reset_async");
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("reset_hold");
    end
    rst = 1'b0;
    n = 0;
    check_all("release");
    accumulate();

    for (int i = 0; i < 12; i++) begin
      while (n < tbl[i].n) begin
        step();
        check_all("walk");
        accumulate();
      end
      vectors++;
      if (hs_w[0] !== tbl[i].hs || vs_w[0] !== tbl[i].vs || tick_w[0] !== tbl[i].tick ||
          hsn_w[0] !== tbl[i].hsn || bn_w[0] !== tbl[i].bn) begin
        miscompares++;
        $display("FAIL tbl[%0d] n=%0d: got hs=%0d vs=%0d tick=%b hsn=%b bn=%b, expected hs=%0d vs=%0d tick=%b hsn=%b bn=%b",
                 i, n, hs_w[0], vs_w[0], tick_w[0], hsn_w[0], bn_w[0],
                 tbl[i].hs, tbl[i].vs, tbl[i].tick, tbl[i].hsn, tbl[i].bn);
      end
    end

    cmp_int("hsync_low_clocks", hsn0_low, 192);
    cmp_int("vsync_low_clocks_small", vsn1_low, 128);
    cmp_int("vga_clk_high_div4", vclk2_hi, 1600);
    cmp_int("tick_count_div4_line", tick2_cnt, 800);
    cmp_int("tick_count_div1_line", tick3_cnt, 800);
    cmp_int("frame_start_count", fs1_cnt, 2);
    cmp_int("frame_start_first", fs1_at[0], 1280);
    cmp_int("frame_start_period", fs1_at[1] - fs1_at[0], 1280);

    // Mid-frame reset while the reduced raster sits inside both sync pulses
    begin
      int budget;
      budget = 0;
      while (!(hs_w[1] == 10'd24 && vs_w[1] == 10'd13) && budget < 3000) begin
        step();
        check_all("seek");
        budget++;
      end
      if (budget >= 3000) begin
        vectors++;
        miscompares++;
        $display("FAIL seek_mid_frame: got timeout after %0d cycles, expected hs=24 vs=13", budget);
      end
      cmp_int("pre_reset_hsync_n", int'(hsn_w[1]), 0);
      cmp_int("pre_reset_vsync_n", int'(vsn_w[1]), 0);
      #2 rst = 1'b1;
      n = 0;
      #1;
      check_all("mid_reset_async");
      step();
      check_all("mid_reset_hold");
      rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
        step();
        check_all("after_mid_reset");
      end
    end

    for (int r = 0; r < 6; r++) begin
      int unsigned len, hold;
      len  = $urandom_range(2500, 100);
      hold = $urandom_range(3, 1);
      for (int unsigned i = 0; i < len; i++) begin
        step();
        check_all("random_run");
      end
      #($urandom_range(4, 1));
      rst = 1'b1;
      n = 0;
      #1;
      check_all("random_reset");
      for (int unsigned i = 0; i < hold; i++) step();
      check_all("random_reset_hold");
      rst = 1'b0;
    end
    for (int i = 0; i < 50; i++) begin
      step();
      check_all("tail");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
